// File: rtl/tmds_des_1to10.sv
// TMDS deserializer and word aligner, 5x pixel-clock domain.
// Assembles 10-bit characters from DDR bit pairs and slips the bit offset until control tokens lock.
module tmds_des_1to10 #(
  parameter int unsigned LOCK_CNT  = 8,
  parameter bit          SWAP_PAIR = 1'b1
) (
  input  logic       clk_x5,
  input  logic       rst,
  input  logic       din_p,
  input  logic       din_n,
  input  logic       resync,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       ctrl_det,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] offset
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);
  localparam logic [2:0] PHASE_LAST = 3'd4;
  localparam logic [3:0] OFFSET_MAX = 4'd9;

  logic [19:0] sh_q;
  logic [2:0]  phase_q;
  logic [3:0]  cnt_q;
  state_t      state_q;

  logic [19:0] win;
  logic [9:0]  raw;
  logic [9:0]  word_d;
  logic        tok_d;
  logic [1:0]  tok_ctrl_d;
  logic [3:0]  cnt_d;
  logic [3:0]  offset_d;

  // Window starts at the current offset; lower sh index is the older bit.
  always_comb begin
    win    = sh_q >> offset;
    raw    = win[9:0];
    word_d = raw;
    if (SWAP_PAIR) begin
      for (int unsigned k = 0; k < 5; k++) begin
        word_d[2*k]   = raw[2*k+1];
        word_d[2*k+1] = raw[2*k];
      end
    end
  end

  always_comb begin
    tok_d      = 1'b1;
    tok_ctrl_d = 2'b00;
    case (word_d)
      10'h354: tok_ctrl_d = 2'b00;
      10'h0AB: tok_ctrl_d = 2'b01;
      10'h154: tok_ctrl_d = 2'b10;
      10'h2AB: tok_ctrl_d = 2'b11;
      default: tok_d      = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d    = (cnt_q >= LOCK_CNT_W) ? LOCK_CNT_W : cnt_q + 4'd1;
    offset_d = (offset >= OFFSET_MAX) ? '0 : offset + 4'd1;
  end

  always_ff @(posedge clk_x5) begin
    if (rst) begin
      sh_q       <= '0;
      phase_q    <= '0;
      cnt_q      <= '0;
      state_q    <= SEARCH;
      data_out   <= '0;
      data_valid <= 1'b0;
      ctrl_det   <= 1'b0;
      ctrl       <= '0;
      locked     <= 1'b0;
      offset     <= '0;
    end else begin
      sh_q       <= {din_n, din_p, sh_q[19:2]};
      phase_q    <= (phase_q == PHASE_LAST) ? '0 : phase_q + 3'd1;
      data_valid <= 1'b0;

      if (phase_q == PHASE_LAST) begin
        data_out   <= word_d;
        data_valid <= 1'b1;
        ctrl_det   <= tok_d;
        ctrl       <= tok_d ? tok_ctrl_d : 2'b00;
      end

      // resync overrides any alignment decision on the same edge, including a slip.
      if (resync) begin
        state_q <= SEARCH;
        locked  <= 1'b0;
        cnt_q   <= '0;
      end else if (phase_q == PHASE_LAST && state_q == SEARCH) begin
        if (tok_d) begin
          if (cnt_d == LOCK_CNT_W) begin
            state_q <= LOCKED;
            locked  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end else begin
          cnt_q  <= '0;
          offset <= offset_d;
        end
      end
    end
  end

endmodule
